// File: rtl/memwb_stage_if.sv
// Memory->writeback stage bundle: upstream instruction fields, memory read return, flush, and the
// register-file write / forwarding outputs. master = pipeline/memory side, slave = the stage.
interface memwb_stage_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic                          in_valid;
  logic                          in_wb_en;
  logic [RADDR_W-1:0]            in_rd;
  logic [SEL_W-1:0]              in_wbs;
  logic                          in_ni;
  logic [(NUM_SRC-1)*DATA_W-1:0] in_src;
  logic                          mem_rvalid;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          flush;
  logic                          stall_out;
  logic                          wb_we;
  logic [RADDR_W-1:0]            wb_rd;
  logic [DATA_W-1:0]             wb_data;
  logic                          wb_ni;
  logic                          fwd_valid;

  modport master (
    output in_valid, in_wb_en, in_rd, in_wbs, in_ni, in_src, mem_rvalid, mem_rdata, flush,
    input  stall_out, wb_we, wb_rd, wb_data, wb_ni, fwd_valid
  );

  modport slave (
    input  in_valid, in_wb_en, in_rd, in_wbs, in_ni, in_src, mem_rvalid, mem_rdata, flush,
    output stall_out, wb_we, wb_rd, wb_data, wb_ni, fwd_valid
  );
endinterface

// File: rtl/memwb_stage.sv
// Memory->writeback pipeline register with writeback-source mux; 1 cycle in->wb, plus one per cycle a load waits.
// Late load data holds the stage in WAIT_MEM and raises stall_out; no downstream back-pressure.
module memwb_stage #(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int NUM_SRC  = 3,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  memwb_stage_if.slave bus
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    READY    = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  typedef struct packed {
    logic               wb_en;
    logic [RADDR_W-1:0] rd;
    logic               ni;
    logic [DATA_W-1:0]  data;
  } wb_fields_t;

  state_t            state_q, state_d;
  wb_fields_t        fld_q, fld_d;
  logic [DATA_W-1:0] src_sel;
  logic              capture;
  logic              rd_is_r0;

  // Register-side sources 1..NUM_SRC-1; select 0 (memory) and illegal encodings fall through to zero.
  always_comb begin
    src_sel = '0;
    for (int k = 1; k < NUM_SRC; k++) begin
      if (bus.in_wbs == SEL_W'(k)) begin
        src_sel = bus.in_src[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  assign capture = (state_q != WAIT_MEM) && bus.in_valid && !bus.flush;

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    case (state_q)
      WAIT_MEM: begin
        // Flush wins over data returning on the same cycle.
        if (bus.flush) begin
          state_d = EMPTY;
        end else if (bus.mem_rvalid) begin
          fld_d.data = bus.mem_rdata;
          state_d    = READY;
        end
      end
      default: begin
        if (capture) begin
          fld_d.wb_en = bus.in_wb_en;
          fld_d.rd    = bus.in_rd;
          fld_d.ni    = bus.in_ni;
          if (bus.in_wbs == '0) begin
            if (bus.mem_rvalid) begin
              fld_d.data = bus.mem_rdata;
              state_d    = READY;
            end else begin
              state_d    = WAIT_MEM;
            end
          end else begin
            fld_d.data = src_sel;
            state_d    = READY;
          end
        end else begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
    end
  end

  assign rd_is_r0      = (ZERO_REG != 0) && (fld_q.rd == '0);
  assign bus.stall_out = (state_q == WAIT_MEM);
  assign bus.wb_we     = (state_q == READY) && fld_q.wb_en && !rd_is_r0;
  assign bus.fwd_valid = bus.wb_we;
  assign bus.wb_rd     = fld_q.rd;
  assign bus.wb_ni     = fld_q.ni;
  assign bus.wb_data   = (state_q == READY) ? fld_q.data : '0;
endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed scenarios plus randomized traffic against a reference model.
module tb_memwb_stage;
  bit   clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  memwb_stage_if #(.DATA_W(16), .RADDR_W(4), .NUM_SRC(3)) bus ();

  memwb_stage #(.DATA_W(16), .RADDR_W(4), .NUM_SRC(3), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_wb_en   = 1'b0;
    bus.in_rd      = 4'd0;
    bus.in_wbs     = 2'd0;
    bus.in_ni      = 1'b0;
    bus.in_src     = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    bus.flush      = 1'b0;
  endtask

  task automatic present(input logic [3:0] rd, input logic [1:0] wbs, input logic [15:0] alu,
                         input logic [15:0] pc1, input logic ni);
    bus.in_valid = 1'b1;
    bus.in_wb_en = 1'b1;
    bus.in_rd    = rd;
    bus.in_wbs   = wbs;
    bus.in_ni    = ni;
    bus.in_src   = {pc1, alu};
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    present(4'd3, 2'd1, 16'h1234, 16'h5678, 1'b1);
    bus.mem_rvalid = 1'b1;
    tick();
    tick();
    total++; if (bus.wb_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.wb_we); end
    total++; if (bus.wb_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", bus.wb_data); end
    total++; if (bus.stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
    total++; if ({bus.wb_rd, bus.wb_ni} !== 5'd0) begin bad++; $display("FAIL reset_fields: rd=%h ni=%b want 0", bus.wb_rd, bus.wb_ni); end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    idle();
    present(4'd3, 2'd1, 16'hFF00, 16'h1111, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h00FF;
    tick();
    total++; if (bus.wb_we !== 1'b1) begin bad++; $display("FAIL alu_we: got %b want 1", bus.wb_we); end
    total++; if (bus.wb_rd !== 4'd3) begin bad++; $display("FAIL alu_rd: got %h want 3", bus.wb_rd); end
    total++; if (bus.wb_data !== 16'hFF00) begin bad++; $display("FAIL alu_data: got %h want ff00", bus.wb_data); end
    total++; if (bus.fwd_valid !== 1'b1) begin bad++; $display("FAIL alu_fwd: got %b want 1", bus.fwd_valid); end
    present(4'd8, 2'd2, 16'hFF00, 16'h1111, 1'b1);
    bus.mem_rvalid = 1'b0;
    tick();
    total++; if (bus.wb_data !== 16'h1111 || bus.wb_rd !== 4'd8 || bus.wb_ni !== 1'b1) begin
      bad++; $display("FAIL pc1_wb: data=%h rd=%h ni=%b want 1111/8/1", bus.wb_data, bus.wb_rd, bus.wb_ni); end
    idle();
    tick();
    total++; if (bus.wb_we !== 1'b0 || bus.wb_data !== 16'h0 || bus.wb_rd !== 4'd8) begin
      bad++; $display("FAIL bubble_after: we=%b data=%h rd=%h want 0/0000/8", bus.wb_we, bus.wb_data, bus.wb_rd); end
  endtask

  task automatic test_hit_load();
    idle();
    present(4'd5, 2'd0, 16'h9999, 16'h8888, 1'b1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h00FF;
    tick();
    total++; if (bus.wb_data !== 16'h00FF || bus.wb_we !== 1'b1 || bus.stall_out !== 1'b0) begin
      bad++; $display("FAIL hit_load: data=%h we=%b stall=%b want 00ff/1/0", bus.wb_data, bus.wb_we, bus.stall_out); end
  endtask

  task automatic test_late_load();
    int stall_cnt;
    idle();
    present(4'd7, 2'd0, 16'h0, 16'h0, 1'b0);
    stall_cnt = 0;
    tick();
    if (bus.stall_out === 1'b1) stall_cnt++;
    present(4'd9, 2'd1, 16'hBEEF, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.stall_out === 1'b1) stall_cnt++;
      total++; if (bus.wb_we !== 1'b0 || bus.wb_rd !== 4'd7) begin
        bad++; $display("FAIL late_hold%0d: we=%b rd=%h want 0/7", i, bus.wb_we, bus.wb_rd); end
    end
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL late_stall_cycles: got %0d want 3", stall_cnt); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hAAAA;
    tick();
    total++; if (bus.wb_we !== 1'b1 || bus.wb_data !== 16'hAAAA || bus.wb_rd !== 4'd7 || bus.stall_out !== 1'b0) begin
      bad++; $display("FAIL late_data: we=%b data=%h rd=%h stall=%b want 1/aaaa/7/0", bus.wb_we, bus.wb_data, bus.wb_rd, bus.stall_out); end
    bus.mem_rvalid = 1'b0;
    tick();
    total++; if (bus.wb_data !== 16'hBEEF || bus.wb_rd !== 4'd9) begin
      bad++; $display("FAIL late_reissue: data=%h rd=%h want beef/9", bus.wb_data, bus.wb_rd); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    present(4'd6, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL flush_enter_wait: stall=%b want 1", bus.stall_out); end
    idle();
    bus.flush      = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h1234;
    tick();
    total++; if (bus.stall_out !== 1'b0 || bus.wb_we !== 1'b0 || bus.wb_data !== 16'h0) begin
      bad++; $display("FAIL flush_wait: stall=%b we=%b data=%h want 0/0/0000", bus.stall_out, bus.wb_we, bus.wb_data); end
    bus.flush = 1'b0;
    tick();
    total++; if (bus.wb_we !== 1'b0 || bus.wb_data !== 16'h0) begin
      bad++; $display("FAIL stray_rvalid: we=%b data=%h want 0/0000", bus.wb_we, bus.wb_data); end
    present(4'd2, 2'd1, 16'h7777, 16'h0, 1'b0);
    bus.flush = 1'b1;
    tick();
    total++; if (bus.wb_we !== 1'b0 || bus.wb_data !== 16'h0 || bus.stall_out !== 1'b0) begin
      bad++; $display("FAIL flush_bubble: we=%b data=%h stall=%b want 0/0000/0", bus.wb_we, bus.wb_data, bus.stall_out); end
    idle();
    tick();
  endtask

  task automatic test_r0_illegal();
    idle();
    present(4'd0, 2'd1, 16'h5555, 16'h0, 1'b0);
    tick();
    total++; if (bus.wb_we !== 1'b0 || bus.fwd_valid !== 1'b0 || bus.wb_data !== 16'h5555) begin
      bad++; $display("FAIL r0_write: we=%b fwd=%b data=%h want 0/0/5555", bus.wb_we, bus.fwd_valid, bus.wb_data); end
    present(4'd4, 2'd3, 16'h5555, 16'h6666, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hABCD;
    tick();
    total++; if (bus.wb_we !== 1'b1 || bus.wb_data !== 16'h0000) begin
      bad++; $display("FAIL illegal_sel: we=%b data=%h want 1/0000", bus.wb_we, bus.wb_data); end
    idle();
    tick();
  endtask

  // Reference: an instruction is either finished (has data), waiting on memory, or absent.
  task automatic test_random();
    logic        m_wait, m_has, m_en, m_ni;
    logic [3:0]  m_rd;
    logic [15:0] m_data;
    logic [15:0] src [0:2];
    logic        e_we, e_stall;
    logic [15:0] e_data;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    {m_wait, m_has, m_en, m_ni, m_rd, m_data} = '0;
    for (int c = 0; c < 500; c++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_wb_en   = 1'($urandom);
      bus.in_rd      = 4'($urandom);
      bus.in_wbs     = 2'($urandom);
      bus.in_ni      = 1'($urandom);
      bus.in_src     = $urandom;
      bus.mem_rvalid = ($urandom_range(0, 2) == 0);
      bus.mem_rdata  = 16'($urandom);
      bus.flush      = ($urandom_range(0, 9) == 0);
      tick();
      src[0] = bus.mem_rdata;
      src[1] = bus.in_src[15:0];
      src[2] = bus.in_src[31:16];
      if (!rst_n) begin
        {m_wait, m_has, m_en, m_ni, m_rd, m_data} = '0;
      end else if (m_wait) begin
        if (bus.flush) m_wait = 1'b0;
        else if (bus.mem_rvalid) begin m_data = src[0]; m_wait = 1'b0; m_has = 1'b1; end
      end else if (bus.in_valid && !bus.flush) begin
        m_en = bus.in_wb_en; m_rd = bus.in_rd; m_ni = bus.in_ni;
        if (bus.in_wbs == 2'd0 && !bus.mem_rvalid) begin m_wait = 1'b1; m_has = 1'b0; end
        else begin m_data = (bus.in_wbs < 2'd3) ? src[bus.in_wbs] : 16'h0; m_has = 1'b1; end
      end else begin
        m_has = 1'b0;
      end
      e_we    = m_has && m_en && (m_rd != 4'd0);
      e_data  = m_has ? m_data : 16'h0;
      e_stall = m_wait;
      total++;
      if (bus.wb_we !== e_we || bus.fwd_valid !== e_we || bus.wb_data !== e_data || bus.stall_out !== e_stall
          || bus.wb_rd !== m_rd || bus.wb_ni !== m_ni) begin
        bad++;
        $display("FAIL rand_cyc%0d: we=%b data=%h stall=%b rd=%h ni=%b want %b/%h/%b/%h/%b", c, bus.wb_we,
                 bus.wb_data, bus.stall_out, bus.wb_rd, bus.wb_ni, e_we, e_data, e_stall, m_rd, m_ni);
      end
      // The bench's upstream must re-present anything it offered while the stage was stalled; since every
      // cycle is re-randomized and the model tracks what the stage actually takes, no extra holding is needed.
    end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_alu();
    test_hit_load();
    test_late_load();
    test_flush();
    test_r0_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
